md_seq_unit: RTL and testbench

Parametrised sequential multiply/divide unit that replaces the separate fixed-32-bit mult and div blocks in the multicycle CPU datapath. It executes signed or unsigned multiply or divide on WIDTH-bit operands and owns the architectural HI/LO registers. The control unit drives it with a start/busy/done handshake. Direct HI/LO writes (MTHI/MTLO) are also supported.

---
 rtl/md_seq_unit.sv | 178 +++++++++++++++++
 tb/tb_md_seq_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_seq_unit.sv
// md_seq_unit: sequential signed/unsigned multiply/divide unit that owns the
// architectural HI/LO registers. One iteration per cycle for WIDTH cycles,
// followed by a single sign-correction cycle that publishes the result.
module md_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_next;

    // Latched operation context.
    logic               is_div_q;   // op[1]: divide rather than multiply
    logic               neg_q;      // sa ^ sb: negate product / quotient
    logic               sa_q;       // dividend sign: negate remainder
    logic               bzero_q;    // divisor was zero
    logic [WIDTH-1:0]   b_mag_q;    // multiplicand / divisor magnitude
    logic [CW-1:0]      cnt_q;

    // Shared accumulator: upper half is partial product / remainder, lower
    // half is multiplier (shifted out) / dividend-becoming-quotient.
    logic [2*WIDTH-1:0] acc_q;

    // Sign flags and operand magnitudes at start.
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // One multiply iteration and one divide iteration.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    // Sign-corrected results.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand sign extraction and magnitude computation.
    always_comb begin
        sa    = a[WIDTH-1] & ~op[0];
        sb    = b[WIDTH-1] & ~op[0];
        a_mag = sa ? (~a + 1'b1) : a;
        b_mag = sb ? (~b + 1'b1) : b;
    end

    // Iteration step for both algorithms plus final sign correction.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a value on
        // every path (defaults first); otherwise synthesis infers a latch.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, b_mag_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_mag_q};
        // When div_ge holds, the true difference is below the divisor and
        // therefore fits in WIDTH bits, so a WIDTH-bit subtract is exact.
        div_diff  = div_shift[WIDTH-1:0] - b_mag_q;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

        prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        // With a zero divisor every step subtracts nothing, so the remainder
        // ends up holding the dividend magnitude; re-applying sa restores the
        // dividend exactly as sampled.
        rem_fix   = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                         : acc_q[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state_q <= IDLE;
        else       state_q <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt_q == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath: operand capture, iteration, result publication, HI/LO writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            bzero_q  <= 1'b0;
            b_mag_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        neg_q    <= sa ^ sb;
                        sa_q     <= sa;
                        bzero_q  <= (b == '0);
                        b_mag_q  <= b_mag;
                        cnt_q    <= '0;
                        acc_q    <= {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (!is_div_q) begin
                        hi       <= prod_fix[2*WIDTH-1:WIDTH];
                        lo       <= prod_fix[WIDTH-1:0];
                        div_zero <= 1'b0;
                    end else if (bzero_q) begin
                        hi       <= rem_fix;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        hi       <= rem_fix;
                        lo       <= quot_fix;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_seq_unit.sv
// tb_md_seq_unit: directed + light random stimulus for md_seq_unit with a
// scoreboard of expected HI/LO/div_zero computed from native 64-bit math.
module tb_md_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    md_seq_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference results from native arithmetic (SV / and % truncate toward 0).
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      r;
        logic [63:0] u;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        e.dz = 1'b0;
        case (o)
            2'b00: begin
                r    = sx * sy;
                e.hi = r[63:32];
                e.lo = r[31:0];
            end
            2'b01: begin
                u    = {32'b0, x} * {32'b0, y};
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            2'b10: begin
                if (y == '0) begin
                    e.dz = 1'b1; e.hi = x; e.lo = '1;
                end else begin
                    r    = sx / sy;
                    e.lo = r[31:0];
                    r    = sx % sy;
                    e.hi = r[31:0];
                end
            end
            default: begin
                if (y == '0) begin
                    e.dz = 1'b1; e.hi = x; e.lo = '1;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    // Present a start request at the current negedge and record the expectation.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb_q.push_back(model(o, x, y));
    endtask

    // Wait (bounded) for done, then check latency, busy profile and result.
    // With meddle set, a new start and HI/LO writes are attempted mid-op.
    task automatic wait_done(input string tag, input bit meddle);
        int   lat      = 0;
        int   busy_cnt = 0;
        exp_t e;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (meddle && i == 5) begin
                start = 1'b1; op = 2'b01; a = 32'h7777_0001; b = 32'h0000_0003;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
            end
            if (meddle && i == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        check($sformatf("%s latency", tag), lat, W + 2);
        check($sformatf("%s busy_cycles", tag), busy_cnt, W + 1);
        check($sformatf("%s busy_at_done", tag), busy, 0);
        e = sb_q.pop_front();
        check($sformatf("%s hi", tag), hi, e.hi);
        check($sformatf("%s lo", tag), lo, e.lo);
        check($sformatf("%s div_zero", tag), div_zero, e.dz);
    endtask

    initial begin
        int dones;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);

        // 1: signed multiply with a negative operand
        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", 1'b0);
        check("mult_neg lo_const", lo, 32'hFFFF_FFEB);

        // 2: MULTU max*max, then back-to-back start in the done cycle
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 1'b0);
        launch(2'b00, 32'd5, 32'd6);
        wait_done("b2b_mult", 1'b0);
        @(negedge clk);
        check("hold done_low", done, 0);
        check("hold lo", lo, 32'd30);

        // 3: signed divide, truncation toward zero and MIN / -1
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 1'b0);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min", 1'b0);

        // 4: divide by zero, then a multiply clears div_zero
        launch(2'b11, 32'h1234_5678, 32'd0);
        wait_done("divu_zero", 1'b0);
        @(negedge clk);
        check("dz held", div_zero, 1);
        launch(2'b01, 32'd3, 32'd4);
        wait_done("multu_clear", 1'b0);

        // 4b: signed divide by zero with negative dividend
        launch(2'b10, 32'hFFFF_FF00, 32'd0);
        wait_done("div_zero_neg", 1'b0);

        // 5: start and HI/LO writes while busy are ignored
        launch(2'b00, 32'h0000_1234, 32'hFFFF_FFF0);
        wait_done("meddle", 1'b1);
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi hi", hi, 32'h0BAD_F00D);
        check("mtlo lo", lo, 32'h0BAD_F00D);
        check("mthi no_done", done, 0);
        check("mthi dz_kept", div_zero, 0);

        // 5b: hi_we with start=1 is ignored
        hi_we = 1'b1; wdata = 32'h1111_2222;
        launch(2'b01, 32'd9, 32'd9);
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_with_start hi", hi, 32'h0BAD_F00D);
        // start was already consumed; the remaining wait still lands on done
        begin
            int lat = 1;
            exp_t e;
            for (int i = 2; i <= 200; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) begin lat = i; break; end
            end
            check("mthi_with_start latency", lat, W + 2);
            e = sb_q.pop_front();
            check("mthi_with_start lo", lo, e.lo);
        end

        // 6: reset mid-divide aborts without a done
        launch(2'b10, 32'd100, 32'd7);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb_q.pop_front());
        check("abort busy", busy, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no_done", dones, 0);
        launch(2'b11, 32'd1000, 32'd7);
        wait_done("after_abort", 1'b0);

        // Light random sweep across all ops
        for (int k = 0; k < 6; k++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            launch(ro, ra, rb);
            wait_done($sformatf("rand%0d", k), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
